// File: rtl/pla_cube_eval_if.sv
// Stream and configuration bundle for pla_cube_eval: cube-table write port,
// input vector handshake (in_valid/in_ready/x) and result handshake (out_valid/out_ready/y).
interface pla_cube_eval_if #(
    parameter int NUM_IN    = 10,
    parameter int NUM_OUT   = 1,
    parameter int NUM_CUBES = 32,
    parameter int AW        = (NUM_CUBES > 1) ? $clog2(NUM_CUBES) : 1
);
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [NUM_IN-1:0]    cfg_care;
    logic [NUM_IN-1:0]    cfg_val;
    logic [NUM_OUT-1:0]   cfg_omask;
    logic                 cfg_en;
    logic [NUM_OUT-1:0]   cfg_inv;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_IN-1:0]    x;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_OUT-1:0]   y;

    // Handshake: a beat transfers on a rising edge where valid && ready are both 1;
    // the producer keeps valid and its data stable until that edge.
    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_en, cfg_inv,
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_en, cfg_inv,
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/pla_cube_eval.sv
// Run-time loadable sum-of-products evaluator: S1 registers the cube match vector,
// S2 registers y = inv ^ OR(match & omask). Two-cycle latency, one vector per cycle.
module pla_cube_eval #(
    parameter int NUM_IN    = 10,
    parameter int NUM_OUT   = 1,
    parameter int NUM_CUBES = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pla_cube_eval_if.slave    bus,
    output logic [CNT_W-1:0]  eval_cnt
);
    logic [NUM_IN-1:0]    care_q  [NUM_CUBES];
    logic [NUM_IN-1:0]    val_q   [NUM_CUBES];
    logic [NUM_OUT-1:0]   omask_q [NUM_CUBES];
    logic [NUM_CUBES-1:0] en_q;
    logic [NUM_OUT-1:0]   inv_q;

    logic                 run_q;
    logic                 adv;
    logic                 take;
    logic                 wr_hit;
    logic [NUM_CUBES-1:0] match;
    logic [NUM_CUBES-1:0] s1_match;
    logic                 s1_valid;
    logic [NUM_OUT-1:0]   inv_eff;
    logic [NUM_OUT-1:0]   y_next;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = run_q && adv && !bus.cfg_we;
    assign take         = bus.in_valid && bus.in_ready;
    assign wr_hit       = bus.cfg_we && (int'(bus.cfg_addr) < NUM_CUBES);
    // A same-cycle inversion write already applies to the vector leaving S1.
    assign inv_eff      = wr_hit ? bus.cfg_inv : inv_q;

    always_comb begin
        match = '0;
        for (int c = 0; c < NUM_CUBES; c++) begin
            match[c] = en_q[c] && (((bus.x ^ val_q[c]) & care_q[c]) == '0);
        end
    end

    always_comb begin
        y_next = '0;
        for (int c = 0; c < NUM_CUBES; c++) begin
            y_next = y_next | (omask_q[c] & {NUM_OUT{s1_match[c]}});
        end
        y_next = y_next ^ inv_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CUBES; c++) begin
                care_q[c]  <= '0;
                val_q[c]   <= '0;
                omask_q[c] <= '0;
            end
            en_q  <= '0;
            inv_q <= '0;
        end else if (wr_hit) begin
            care_q[bus.cfg_addr]  <= bus.cfg_care;
            val_q[bus.cfg_addr]   <= bus.cfg_val;
            omask_q[bus.cfg_addr] <= bus.cfg_omask;
            en_q[bus.cfg_addr]    <= bus.cfg_en;
            inv_q                 <= bus.cfg_inv;
        end
    end

    // run_q keeps in_ready low while reset is held and opens it one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_match      <= '0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
        end else if (adv) begin
            s1_valid      <= take;
            bus.out_valid <= s1_valid;
            if (take) begin
                s1_match <= match;
            end
            if (s1_valid) begin
                bus.y <= y_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            eval_cnt <= eval_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pla_cube_eval.sv
// Bench for pla_cube_eval: directed tables and sequences plus random streaming
// against a cube-table model; a second instance with a 4-bit counter checks wrap.
module tb_pla_cube_eval;
    localparam int NI = 10;
    localparam int NO = 1;
    localparam int NC = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pla_cube_eval_if #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(NC)) bus ();
    pla_cube_eval_if #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(NC)) bus4 ();

    logic [15:0] eval_cnt;
    logic [3:0]  eval_cnt4;

    pla_cube_eval #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(NC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .eval_cnt(eval_cnt)
    );
    pla_cube_eval #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_CUBES(NC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .eval_cnt(eval_cnt4)
    );

    assign bus4.cfg_we    = bus.cfg_we;
    assign bus4.cfg_addr  = bus.cfg_addr;
    assign bus4.cfg_care  = bus.cfg_care;
    assign bus4.cfg_val   = bus.cfg_val;
    assign bus4.cfg_omask = bus.cfg_omask;
    assign bus4.cfg_en    = bus.cfg_en;
    assign bus4.cfg_inv   = bus.cfg_inv;
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.x         = bus.x;
    assign bus4.out_ready = bus.out_ready;

    // Cube-table model
    logic [NI-1:0] m_care  [NC];
    logic [NI-1:0] m_val   [NC];
    logic [NO-1:0] m_omask [NC];
    logic          m_en    [NC];
    logic [NO-1:0] m_inv;

    logic [NO-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int xfers = 0;

    typedef struct {
        logic [NI-1:0] x;
        logic [NO-1:0] y;
    } vec_t;
    vec_t tv[6];

    function automatic logic [NO-1:0] model_y(input logic [NI-1:0] xv);
        logic [NO-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            if (m_en[c] && ((xv & m_care[c]) == (m_val[c] & m_care[c]))) r = r | m_omask[c];
        end
        return r ^ m_inv;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NC; c++) begin
            m_care[c] = '0; m_val[c] = '0; m_omask[c] = '0; m_en[c] = 1'b0;
        end
        m_inv = '0;
        exp_q.delete();
        xfers = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got y=%0h expected no output at %0t", bus.y, $time);
            end else begin
                check("y", 32'(bus.y), 32'(exp_q.pop_front()));
            end
            xfers++;
        end
    end

    // Called just after a rising edge; returns just after the write edge.
    task automatic cfg_write(input int addr, input logic [NI-1:0] care, input logic [NI-1:0] val,
                             input logic [NO-1:0] om, input logic en, input logic [NO-1:0] inv);
        bus.cfg_addr = AW'(addr); bus.cfg_care = care; bus.cfg_val = val;
        bus.cfg_omask = om; bus.cfg_en = en; bus.cfg_inv = inv; bus.cfg_we = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        m_care[addr] = care; m_val[addr] = val; m_omask[addr] = om; m_en[addr] = en;
        m_inv = inv;
    endtask

    task automatic send(input logic [NI-1:0] xv, input logic [NO-1:0] e);
        bit got = 0;
        bus.in_valid = 1'b1;
        bus.x = xv;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                got = 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        rst_n = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NI-1:0] r;
        logic [NI-1:0] vals[3];
        logic [NO-1:0] y_hold;
        int idx;
        bit done;

        tv[0] = '{10'h155, 1'b1};
        tv[1] = '{10'h154, 1'b0};
        tv[2] = '{10'h355, 1'b0};
        tv[3] = '{10'h3FF, 1'b0};
        tv[4] = '{10'h000, 1'b0};
        tv[5] = '{10'h155, 1'b1};

        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0;
        bus.cfg_omask = '0; bus.cfg_en = 0; bus.cfg_inv = '0;
        bus.in_valid = 0; bus.x = '0; bus.out_ready = 1'b1;
        clear_model();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_y", 32'(bus.y), 0);
        check("rst_eval_cnt", 32'(eval_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_reset", 32'(bus.in_ready), 1);

        // Empty table with latency check
        send(10'h000, 1'b0);
        @(negedge clk);
        check("lat_s1", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_s2", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        send(10'h3FF, 1'b0);
        drain();
        cfg_write(0, '0, '0, '0, 1'b0, 1'b1);
        send(10'h12A, 1'b1);
        drain();

        // Single full-care cube, table-driven
        cfg_write(0, 10'h3FF, 10'h155, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send(tv[i].x, tv[i].y);
        drain();

        // Tautology cube, then disabled
        cfg_write(1, '0, NI'($urandom), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(NI'($urandom), 1'b1);
        drain();
        cfg_write(1, '0, '0, 1'b1, 1'b0, 1'b0);
        send(10'h0F0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            r = NI'($urandom);
            send(r, model_y(r));
        end
        drain();

        // Backpressure: two accepts, then stall with stable output
        do_reset();
        cfg_write(0, 10'h3FF, 10'h001, 1'b1, 1'b1, 1'b0);
        vals[0] = 10'h001; vals[1] = 10'h002; vals[2] = 10'h001;
        bus.out_ready = 1'b0;
        idx = 0;
        bus.in_valid = 1'b1;
        bus.x = vals[0];
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready && idx < 3) begin
                exp_q.push_back(model_y(vals[idx]));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 3) bus.x = vals[idx];
        end
        check("bp_accepts", idx, 2);
        y_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_y_hold", 32'(bus.y), 32'(y_hold));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 3; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model_y(vals[idx]));
                idx++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drain();
        check("bp_eval_cnt", 32'(eval_cnt), 3);

        // Vector in S1 during a write: old matches, new inversion
        cfg_write(2, 10'h3FF, 10'h0AA, 1'b1, 1'b1, 1'b0);
        send(10'h0AA, 1'b1);
        cfg_write(2, 10'h3FF, 10'h155, 1'b1, 1'b1, 1'b0);
        drain();
        send(10'h000, 1'b1);
        cfg_write(3, '0, '0, '0, 1'b0, 1'b1);
        drain();
        send(10'h000, model_y(10'h000));
        drain();

        // Write/accept collision: write wins, vector taken next cycle with new cube
        bus.x = 10'h2F0;
        bus.in_valid = 1'b1;
        bus.cfg_addr = AW'(4); bus.cfg_care = 10'h3FF; bus.cfg_val = 10'h2F0;
        bus.cfg_omask = 1'b1; bus.cfg_en = 1'b1; bus.cfg_inv = 1'b0; bus.cfg_we = 1'b1;
        @(negedge clk);
        check("collide_no_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        m_care[4] = 10'h3FF; m_val[4] = 10'h2F0; m_omask[4] = 1'b1; m_en[4] = 1'b1; m_inv = 1'b0;
        @(negedge clk);
        check("collide_ready_next", 32'(bus.in_ready), 1);
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Random table and stream under random backpressure
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cfg_write(c, NI'($urandom & $urandom & $urandom), NI'($urandom), 1'b1,
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        cfg_write(9, NI'($urandom & $urandom), NI'($urandom), 1'b1, 1'b1, m_inv);
        done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    r = NI'($urandom);
                    send(r, model_y(r));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        check("rand_eval_cnt", 32'(eval_cnt), 150);
        check("rand_cnt4_mod", 32'(eval_cnt4), 150 % 16);

        // Async reset with two vectors in flight
        send(10'h011, 1'b0);
        send(10'h022, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_eval_cnt", 32'(eval_cnt), 0);
        check("arst_in_ready", 32'(bus.in_ready), 0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_out", 32'(bus.out_valid), 0);
        end
        @(posedge clk); #1;

        // 4-bit counter wrap
        for (int i = 0; i < 15; i++) begin
            r = NI'($urandom);
            send(r, model_y(r));
        end
        drain();
        check("cnt4_at_15", 32'(eval_cnt4), 15);
        send(10'h0F0, model_y(10'h0F0));
        drain();
        check("cnt4_wrap", 32'(eval_cnt4), 0);
        check("cnt16_at_16", 32'(eval_cnt), 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pla_cube_eval.md
Name: pla_cube_eval

Overview:
- Programmable, pipelined sum-of-products evaluator. A generalised, run-time-loadable successor to our fixed 10-input/1-output PLA netlists.
- A cube table is written over a config port. Input vectors stream in through a valid/ready handshake.
- Each accepted vector produces NUM_OUT output bits two cycles later. Each output bit can optionally be inverted, which covers ON-set and OFF-set covers.
- Sits between the benchmark stimulus source and the result checker in the autosymmetry test harness.

Parameters:
- NUM_IN, 10, input variables per vector (x width).
- NUM_OUT, 1, outputs (y width).
- NUM_CUBES, 32, product terms in the table.
- CNT_W, 16, width of the evaluation counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  cube write strobe.
- cfg_addr  in  clog2(NUM_CUBES)  cube index.
- cfg_care  in  NUM_IN  care mask; 1 = literal present.
- cfg_val  in  NUM_IN  literal polarity where care=1.
- cfg_omask  in  NUM_OUT  outputs this cube feeds.
- cfg_en  in  1  cube valid bit.
- cfg_inv  in  NUM_OUT  output inversion; written together with any cube write.
- in_valid  in  1  x is valid.
- in_ready  out  1  block accepts x this cycle.
- x  in  NUM_IN  input vector.
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  NUM_OUT  function value.
- eval_cnt  out  CNT_W  count of completed output transfers.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - all cube en bits = 0; inv = 0.
  - stage valids = 0; out_valid = 0; y = 0; eval_cnt = 0.
  - in_ready = 0 during reset, and 1 in the first cycle after rst_n rises.
- Cube match:
  - cube c matches x iff en[c] && ((x ^ val[c]) & care[c]) == 0.
  - care = 0 gives a tautology cube, which matches every x.
- Output function: y[o] = inv[o] ^ OR over c of (match[c] && omask[c][o]).
  - With no enabled cubes, y = inv.
- Pipeline:
  - S1 registers the match vector (NUM_CUBES bits).
  - S2 registers y, which is the module output.
  - Latency: an x accepted in cycle t gives out_valid in cycle t+2 when there is no backpressure.
- Advance: adv = !out_valid || out_ready.
  - When adv, S1 moves to S2 and a new x is captured into S1.
  - When !adv, both stages hold; no bubble collapse is required.
- in_ready = adv && !cfg_we.
  - A transfer occurs only when in_valid && in_ready.
  - in_valid may be held across stalls; x must then be held stable.
- Throughput: one vector per cycle when out_ready is continuously 1.
- Config writes:
  - take effect at the clock edge of cfg_we.
  - Vectors already in S1 use the old table (matches are already registered).
  - Vectors accepted afterwards use the new table.
  - cfg_inv is applied at S2 capture, so the vector in S1 at write time sees the new inv. This is intended and must be verified.
- Simultaneous cfg_we with in_valid: the write wins and the vector is not accepted (in_ready = 0).
- Writing the same cfg_addr on consecutive cycles: the last write wins.
- cfg_addr >= NUM_CUBES: the write is ignored.
- eval_cnt increments on each out_valid && out_ready transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-stream: in-flight vectors are discarded, the table is cleared, and no out_valid follows for vectors accepted before reset.
- Mode coverage: NUM_IN 1..16, NUM_OUT 1..8, NUM_CUBES 1..64. NUM_CUBES = 1 uses a 1-bit cfg_addr.

Test Plan:
- Reset then empty table, inv=0:
  - stream x=0x000, 0x3FF → y=0, 0 at t+2, t+3.
  - set inv=1 via a write with cfg_en=0 → next y=1.
- Cube 0 care=0x3FF, val=0x155, omask=1, en=1:
  - x=0x155 → y=1.
  - x=0x154 → y=0.
  - x=0x355 → y=0.
- Tautology cube (care=0, en=1):
  - 5 random x → y=1 each.
  - then disable it with en=0 → y=0 for the following vectors.
- Backpressure:
  - hold out_ready=0 with 3 vectors offered → in_ready=0 after 2 accepts; out_valid and y stable.
  - release out_ready → results emerge in order, eval_cnt = 3.
- Write/accept collision:
  - in_valid=1 with cfg_we=1 in the same cycle → no transfer that cycle.
  - the vector is accepted the next cycle and evaluated with the new cube.
- Async reset with 2 vectors in flight:
  - out_valid=0 immediately; eval_cnt=0.
  - no stale outputs after release; CNT_W=4 wrap check 15→0.
